enc_cw_serializer: RTL and testbench

- Downstream stage of the message and parity buffers.
- On a start pulse it snapshots the full message-buffer contents and parity-buffer contents into a shadow register. This frees the message buffer to keep shifting in the next message.
- It then emits the systematic codeword ENC_SYM symbols per beat over a valid/ready stream with a last flag.
- It also drives a stall toward the generator, which feeds the message buffer's con_stall, when it cannot accept a new codeword.

---
 rtl/enc_cw_serializer_pkg.sv | 37 +++
 rtl/enc_cw_serializer_if.sv | 32 +++
 rtl/enc_cw_shadow.sv | 47 ++++
 rtl/enc_cw_serializer.sv | 129 ++++++++++++
 tb/tb_enc_cw_serializer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/enc_cw_serializer_pkg.sv
// -----------------------------------------------------------------------------
// enc_cw_serializer_pkg
// Shared constants and types for the codeword serializer: field symbol width,
// beat width, buffer depths, derived codeword length / beat count, the symbol
// and bus types, and the serializer state encoding.
// -----------------------------------------------------------------------------
package enc_cw_serializer_pkg;

  localparam int EGF_DIM         = 8;
  localparam int ENC_SYM         = 4;
  localparam int ENC_MES_BUF_DEP = 16;
  localparam int ENC_PAR_BUF_DEP = 8;

  localparam int ENC_CW_LEN   = ENC_MES_BUF_DEP + ENC_PAR_BUF_DEP;
  localparam int ENC_CW_BEATS = ENC_CW_LEN / ENC_SYM;
  localparam int ENC_CW_CNT_W = (ENC_CW_BEATS > 1) ? $clog2(ENC_CW_BEATS) : 1;

  typedef logic [EGF_DIM-1:0] sym_t;

  // Buffer images: element DEP-1 is the oldest message symbol / highest parity.
  typedef sym_t [ENC_MES_BUF_DEP-1:0] mes_buf_t;
  typedef sym_t [ENC_PAR_BUF_DEP-1:0] par_buf_t;

  // Codeword in transmission order: element n is codeword symbol n.
  typedef sym_t [ENC_CW_LEN-1:0] cw_t;

  // One output beat: element j is lane j.
  typedef sym_t [ENC_SYM-1:0] beat_t;

  typedef logic [ENC_CW_CNT_W-1:0] beat_cnt_t;

  typedef enum logic {
    CWS_IDLE = 1'b0,
    CWS_SEND = 1'b1
  } cws_state_t;

endpackage

// File: rtl/enc_cw_serializer_if.sv
// -----------------------------------------------------------------------------
// enc_cw_serializer_if
// Output beat stream of the codeword serializer.
//   out_valid  beat on out_data is valid
//   out_ready  downstream accepts the beat
//   out_data   ENC_SYM lanes, lane j = codeword symbol beat*ENC_SYM+j
//   out_last   final beat of the codeword
// master: the serializer; slave: the downstream consumer.
// -----------------------------------------------------------------------------
interface enc_cw_serializer_if;
  import enc_cw_serializer_pkg::*;

  logic  out_valid;
  logic  out_ready;
  beat_t out_data;
  logic  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/enc_cw_shadow.sv
// -----------------------------------------------------------------------------
// enc_cw_shadow
// Captures the message and parity buffers into a shadow register already laid
// out in transmission order (oldest message symbol first, then parity from the
// highest degree down), so the upstream buffers are free right after capture.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset (shadow clears to 0)
//   i_load      capture strobe
//   i_mes       message buffer image (index DEP-1 oldest)
//   i_par       parity buffer image (index DEP-1 highest degree)
//   o_shadow    registered codeword, element n = codeword symbol n
// -----------------------------------------------------------------------------
module enc_cw_shadow
  import enc_cw_serializer_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_load,
  input  mes_buf_t i_mes,
  input  par_buf_t i_par,
  output cw_t      o_shadow
);

  cw_t w_ordered;
  cw_t r_shadow;

  genvar gi;
  generate
    for (gi = 0; gi < ENC_MES_BUF_DEP; gi++) begin : g_mes
      assign w_ordered[gi] = i_mes[ENC_MES_BUF_DEP-1-gi];
    end
    for (gi = 0; gi < ENC_PAR_BUF_DEP; gi++) begin : g_par
      assign w_ordered[ENC_MES_BUF_DEP+gi] = i_par[ENC_PAR_BUF_DEP-1-gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (i_load) begin
      r_shadow <= w_ordered;
    end
  end

  assign o_shadow = r_shadow;

endmodule

// File: rtl/enc_cw_serializer.sv
// -----------------------------------------------------------------------------
// enc_cw_serializer
// On an accepted cw_start, snapshots the message and parity buffers and then
// streams the systematic codeword ENC_SYM symbols per beat with a last flag.
// A new codeword may be accepted on the cycle the final beat handshakes, so
// codewords can run back to back with no idle cycle.
// Ports:
//   clk, rst_n         clock / asynchronous active-low reset
//   i_cw_start         both buffers hold a complete codeword
//   i_mes_buf_data     message buffer (index DEP-1 oldest)
//   i_par_buf_data     parity buffer (index DEP-1 highest degree)
//   o_cw_start_ready   a snapshot can be taken this cycle
//   o_con_stall        stall toward the generator / message buffer
//   o_cw               output beat stream (master side)
// -----------------------------------------------------------------------------
module enc_cw_serializer
  import enc_cw_serializer_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_cw_start,
  input  mes_buf_t                    i_mes_buf_data,
  input  par_buf_t                    i_par_buf_data,
  output logic                        o_cw_start_ready,
  output logic                        o_con_stall,
  enc_cw_serializer_if.master         o_cw
);

  generate
    if ((ENC_MES_BUF_DEP + ENC_PAR_BUF_DEP) % ENC_SYM != 0) begin : g_len_chk
      $error("codeword length must be a multiple of ENC_SYM");
    end
  endgenerate

  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(ENC_CW_BEATS - 1);

  cws_state_t r_state;
  cws_state_t w_state_next;
  beat_cnt_t  r_beat_cnt;
  beat_cnt_t  w_beat_cnt_next;

  logic  w_valid;
  logic  w_last;
  logic  w_hs;
  logic  w_start_ready;
  logic  w_stall;
  logic  w_load;
  cw_t   w_shadow;
  beat_t w_beats [ENC_CW_BEATS];

  enc_cw_shadow u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_mes    (i_mes_buf_data),
    .i_par    (i_par_buf_data),
    .o_shadow (w_shadow)
  );

  // Split the shadow into its beats so out_data is a plain beat-index mux.
  genvar gi;
  generate
    for (gi = 0; gi < ENC_CW_BEATS; gi++) begin : g_beat
      assign w_beats[gi] = w_shadow[gi*ENC_SYM +: ENC_SYM];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CWS_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_beat_cnt_next = r_beat_cnt;
    w_valid         = 1'b0;
    w_last          = 1'b0;
    w_hs            = 1'b0;
    w_start_ready   = 1'b0;
    w_stall         = 1'b0;

    case (r_state)
      CWS_IDLE: begin
        w_start_ready = 1'b1;
        if (i_cw_start) begin
          w_state_next    = CWS_SEND;
          w_beat_cnt_next = '0;
        end
      end
      CWS_SEND: begin
        w_valid = 1'b1;
        w_last  = (r_beat_cnt == LAST_BEAT);
        w_hs    = o_cw.out_ready;
        // The upstream may refill the shadow in the same cycle the last
        // beat leaves, which is what allows zero-gap codewords.
        w_start_ready = w_hs & w_last;
        w_stall       = ~(o_cw.out_ready & w_last);
        if (w_hs) begin
          if (w_last) begin
            w_beat_cnt_next = '0;
            if (!i_cw_start) begin
              w_state_next = CWS_IDLE;
            end
          end else begin
            w_beat_cnt_next = r_beat_cnt + beat_cnt_t'(1);
          end
        end
      end
      default: begin
        w_state_next    = CWS_IDLE;
        w_beat_cnt_next = '0;
      end
    endcase
  end

  assign w_load = i_cw_start & w_start_ready;

  assign o_cw_start_ready = w_start_ready;
  assign o_con_stall      = w_stall;
  assign o_cw.out_valid   = w_valid;
  assign o_cw.out_last    = w_last;
  assign o_cw.out_data    = w_valid ? w_beats[r_beat_cnt] : '0;

endmodule

// File: tb/tb_enc_cw_serializer.sv
module tb_enc_cw_serializer;
  import enc_cw_serializer_pkg::*;

  logic     clk;
  logic     rst_n;
  logic     cw_start;
  mes_buf_t mes;
  par_buf_t par;
  logic     cw_start_ready;
  logic     con_stall;

  enc_cw_serializer_if u_if ();

  enc_cw_serializer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_cw_start       (cw_start),
    .i_mes_buf_data   (mes),
    .i_par_buf_data   (par),
    .o_cw_start_ready (cw_start_ready),
    .o_con_stall      (con_stall),
    .o_cw             (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state: reflects the DUT state of the current cycle.
  beat_t sb[$];
  int    m_cnt  = 0;
  bit    m_send = 1'b0;

  always @(negedge clk) begin
    bit    exp_last;
    bit    exp_rdy;
    bit    accept;
    beat_t e;
    if (!rst_n) begin
      m_send = 1'b0;
      m_cnt  = 0;
      sb.delete();
    end else begin
      exp_last = m_send && (m_cnt == ENC_CW_BEATS - 1);
      exp_rdy  = !m_send || (u_if.out_ready && exp_last);
      check("valid", u_if.out_valid, m_send);
      check("last", u_if.out_last, exp_last);
      check("start_ready", cw_start_ready, exp_rdy);
      check("con_stall", con_stall, m_send && !(u_if.out_ready && exp_last));
      if (!m_send) check("idle_data", u_if.out_data, '0);

      if (u_if.out_valid && u_if.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("beat_data", u_if.out_data, e);
          $display("beat %0d data=%h last=%b", m_cnt, u_if.out_data, u_if.out_last);
        end
      end else if (u_if.out_valid && sb.size() > 0) begin
        check("hold_data", u_if.out_data, sb[0]);
      end

      accept = cw_start && exp_rdy;
      if (cw_start && !exp_rdy)
        $display("protocol: cw_start while not ready, ignored");

      if (m_send && u_if.out_ready) begin
        if (exp_last) begin
          m_send = accept;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end else if (!m_send && accept) begin
        m_send = 1'b1;
        m_cnt  = 0;
      end

      if (accept) begin
        for (int b = 0; b < ENC_CW_BEATS; b++) begin
          for (int j = 0; j < ENC_SYM; j++) begin
            int n;
            n = b * ENC_SYM + j;
            if (n < ENC_MES_BUF_DEP) e[j] = mes[ENC_MES_BUF_DEP-1-n];
            else                     e[j] = par[ENC_PAR_BUF_DEP-1-(n-ENC_MES_BUF_DEP)];
          end
          sb.push_back(e);
        end
        $display("start accepted, %0d beats queued", ENC_CW_BEATS);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int mbase, input int pbase);
    for (int k = 0; k < ENC_MES_BUF_DEP; k++) mes[ENC_MES_BUF_DEP-1-k] = sym_t'(mbase + k);
    for (int k = 0; k < ENC_PAR_BUF_DEP; k++) par[ENC_PAR_BUF_DEP-1-k] = sym_t'(pbase + k);
  endtask

  task automatic start_cw();
    cw_start = 1'b1;
    tick();
    cw_start = 1'b0;
  endtask

  task automatic wait_beat(input int n);
    int i;
    for (i = 0; i < 40; i++) begin
      if (m_send && m_cnt == n) break;
      tick();
    end
    if (i == 40) check("wait_timeout", 0, 1);
  endtask

  initial begin
    rst_n           = 1'b0;
    cw_start        = 1'b0;
    u_if.out_ready  = 1'b1;
    set_data(8'h01, 8'hA1);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_start_ready", cw_start_ready, 1);
    check("rst_valid", u_if.out_valid, 0);
    check("rst_stall", con_stall, 0);
    check("rst_data", u_if.out_data, 0);
    check("rst_last", u_if.out_last, 0);

    // Single codeword, always ready
    start_cw();
    check("single_beat0", u_if.out_data, 64'h04030201);
    repeat (8) tick();

    // Backpressure at beat 2
    start_cw();
    wait_beat(2);
    u_if.out_ready = 1'b0;
    repeat (3) tick();
    check("bp_beat2", u_if.out_data, 64'h0C0B0A09);
    u_if.out_ready = 1'b1;
    repeat (8) tick();

    // Back-to-back codewords
    start_cw();
    wait_beat(5);
    check("b2b_beat5", u_if.out_data, 64'hA8A7A6A5);
    set_data(8'h11, 8'hB1);
    start_cw();
    check("b2b_new_beat0", u_if.out_data, 64'h14131211);
    repeat (8) tick();

    // Early start is ignored
    set_data(8'h01, 8'hA1);
    start_cw();
    wait_beat(2);
    set_data(8'h55, 8'h66);
    start_cw();
    repeat (8) tick();

    // Snapshot isolation: inputs churn after the accepted start
    set_data(8'h21, 8'hC1);
    start_cw();
    for (int i = 0; i < 8; i++) begin
      set_data(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      tick();
    end

    // Reset mid-stream
    set_data(8'h31, 8'hD1);
    start_cw();
    wait_beat(3);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", u_if.out_valid, 0);
    check("midrst_data", u_if.out_data, 0);
    check("midrst_start_ready", cw_start_ready, 1);
    check("midrst_stall", con_stall, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    set_data(8'h41, 8'hE1);
    start_cw();
    check("restart_beat0", u_if.out_data, 64'h44434241);
    repeat (8) tick();

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
